// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC register, imem request, IF/ID register
module fetch_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            id_stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ready,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instr,
  output logic            if_id_valid,
  output logic            misalign_err
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t          state;
  logic [XLEN-1:0] pc;

  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      imem_req     <= 1'b0;
      if_id_pc     <= '0;
      if_id_instr  <= NOP_INSTR;
      if_id_valid  <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state    <= RUN;
          imem_req <= 1'b1;
        end
        RUN: begin
          if (branch_taken && (branch_target[1:0] != 2'b00)) begin
            // Misaligned redirect: freeze fetch until reset, keep the bad PC out of pc.
            state        <= HALT;
            imem_req     <= 1'b0;
            misalign_err <= 1'b1;
            if_id_valid  <= 1'b0;
            if_id_instr  <= NOP_INSTR;
          end else if (branch_taken) begin
            // Redirect wins over a decode stall: the held instruction is on the wrong path.
            pc          <= branch_target;
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
          end else if (id_stall) begin
            pc <= pc;
          end else if (imem_ready) begin
            if_id_pc    <= pc;
            if_id_instr <= imem_rdata;
            if_id_valid <= 1'b1;
            pc          <= pc + XLEN'(4);
          end else begin
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
          end
        end
        HALT: begin
          imem_req    <= 1'b0;
          if_id_valid <= 1'b0;
          if_id_instr <= NOP_INSTR;
        end
        default: begin
          state    <= HALT;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed plus randomized checks of fetch_stage against a spec-level model
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, branch_taken, id_stall, imem_ready;
  logic [31:0] branch_target, imem_rdata, imem_addr, if_id_pc, if_id_instr;
  logic        imem_req, if_id_valid, misalign_err;

  logic [31:0] imem_rdata2, imem_addr2, if_id_pc2, if_id_instr2;
  logic        imem_req2, if_id_valid2, misalign_err2;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state, written in terms of the observable behaviour.
  bit          m_boot, m_halt, m_valid, m_err;
  logic [31:0] m_pc, m_ifpc, m_instr;

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign imem_rdata  = imem_ready ? word(imem_addr) : 32'hDEAD_BEEF;
  assign imem_rdata2 = word(imem_addr2);

  fetch_stage dut (
    .clk(clk), .rst(rst), .branch_taken(branch_taken), .branch_target(branch_target),
    .id_stall(id_stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
    .if_id_valid(if_id_valid), .misalign_err(misalign_err)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst), .branch_taken(1'b0), .branch_target(32'h0),
    .id_stall(1'b0), .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .imem_ready(1'b1), .if_id_pc(if_id_pc2), .if_id_instr(if_id_instr2),
    .if_id_valid(if_id_valid2), .misalign_err(misalign_err2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_boot = 1; m_halt = 0; m_pc = 32'h0; m_ifpc = 32'h0;
      m_instr = NOP; m_valid = 0; m_err = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (m_halt) begin
      m_valid = 0; m_instr = NOP;
    end else if (branch_taken && branch_target[1:0] != 2'b00) begin
      m_err = 1; m_halt = 1; m_valid = 0; m_instr = NOP;
    end else if (branch_taken) begin
      m_pc = branch_target; m_valid = 0; m_instr = NOP;
    end else if (id_stall) begin
      m_pc = m_pc;
    end else if (imem_ready) begin
      m_ifpc = m_pc; m_instr = word(m_pc); m_valid = 1; m_pc = m_pc + 32'd4;
    end else begin
      m_valid = 0; m_instr = NOP;
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    chk("imem_req", 32'(imem_req), 32'(!m_boot && !m_halt));
    chk("imem_addr", imem_addr, m_pc);
    chk("if_id_valid", 32'(if_id_valid), 32'(m_valid));
    chk("if_id_instr", if_id_instr, m_instr);
    chk("misalign_err", 32'(misalign_err), 32'(m_err));
    if (m_valid) chk("if_id_pc", if_id_pc, m_ifpc);
  endtask

  initial begin
    logic [31:0] exp1 [4];
    logic [31:0] exp2 [4];
    exp1 = '{32'h0, 32'h0, 32'h4, 32'h8};
    exp2 = '{32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
    m_boot = 0; m_halt = 0; m_valid = 0; m_err = 0;
    m_pc = 0; m_ifpc = 0; m_instr = NOP;
    rst = 1; branch_taken = 0; branch_target = 0; id_stall = 0; imem_ready = 1;

    cycle();
    chk("rst_pc", if_id_pc, 32'h0);
    chk("rst_instr", if_id_instr, NOP);
    chk("rst_req", 32'(imem_req), 32'h0);
    rst = 0;

    // Sequential fetch; the wrap-around instance runs alongside.
    cycle();
    chk("boot_req", 32'(imem_req), 32'h1);
    for (int i = 1; i < 4; i++) begin
      cycle();
      chk("seq_pc", if_id_pc, exp1[i]);
      chk("seq_valid", 32'(if_id_valid), 32'h1);
      chk("wrap_pc", if_id_pc2, exp2[i]);
    end

    // Stall three edges while if_id_pc is 8.
    id_stall = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_pc", if_id_pc, 32'h8);
      chk("stall_fetch_pc", imem_addr, 32'hC);
      if (i == 0) chk("wrap_pc4", if_id_pc2, 32'h4);
    end
    id_stall = 0;
    cycle();
    chk("resume_pc", if_id_pc, 32'hC);

    // Branch with a simultaneous stall still flushes.
    branch_taken = 1; branch_target = 32'h40; id_stall = 1;
    cycle();
    chk("br_valid", 32'(if_id_valid), 32'h0);
    chk("br_instr", if_id_instr, NOP);
    chk("br_pc", imem_addr, 32'h40);
    branch_taken = 0; id_stall = 0;
    cycle();
    chk("br_target_pc", if_id_pc, 32'h40);
    chk("br_target_valid", 32'(if_id_valid), 32'h1);

    // Two wait states then the next word.
    imem_ready = 0;
    repeat (2) begin
      cycle();
      chk("wait_valid", 32'(if_id_valid), 32'h0);
      chk("wait_addr", imem_addr, 32'h44);
    end
    imem_ready = 1;
    cycle();
    chk("wait_pc", if_id_pc, 32'h44);
    chk("wait_instr", if_id_instr, word(32'h44));

    // Randomized traffic, including occasional resets and misaligned redirects.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      branch_taken = ($urandom_range(0, 9) == 0);
      branch_target = {22'h0, 8'($urandom_range(0, 255)),
                       ($urandom_range(0, 24) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
      id_stall = ($urandom_range(0, 4) == 0);
      imem_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end

    // Misaligned redirect halts fetch until reset.
    rst = 1; branch_taken = 0; id_stall = 0; imem_ready = 1;
    cycle();
    rst = 0;
    repeat (4) cycle();
    branch_taken = 1; branch_target = 32'h42;
    cycle();
    for (int i = 0; i < 10; i++) begin
      branch_taken = 1'($urandom_range(0, 1));
      branch_target = 32'h80;
      id_stall = 1'($urandom_range(0, 1));
      cycle();
      chk("halt_err", 32'(misalign_err), 32'h1);
      chk("halt_req", 32'(imem_req), 32'h0);
      chk("halt_valid", 32'(if_id_valid), 32'h0);
    end
    rst = 1; branch_taken = 0; id_stall = 0;
    cycle();
    chk("rst2_err", 32'(misalign_err), 32'h0);
    chk("rst2_addr", imem_addr, 32'h0);
    chk("rst2_pc", if_id_pc, 32'h0);
    rst = 0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
